mouse_transmitter: RTL

Host-to-device PS/2 byte transmitter for the mouse interface. It sends one command byte (for example 0xF4 Enable Data Reporting or 0xFF Reset) to the mouse. It drives the shared open-drain CLK/DATA lines through output-enable signals and sits beside the mouse receiver under the mouse master state machine. It performs the request-to-send sequence, shifts data on device clock edges, checks the device ACK and reports completion or error.

---
 rtl/mouse_transmitter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mouse_transmitter.sv
`timescale 1ns/1ps
// mouse_transmitter: PS/2 host-to-device byte sender driving the open-drain mouse CLK/DATA lines via output enables.
// Performs request-to-send, shifts the frame on device falling edges, checks the ACK and enforces an inter-edge timeout.
module mouse_transmitter #(
   parameter int CLK_HOLD_CYCLES    = 5000,
   parameter int RTS_OVERLAP_CYCLES = 20,
   parameter int TIMEOUT_CYCLES     = 50000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   output logic       CLK_MOUSE_OUT_EN,
   input  logic       DATA_MOUSE_IN,
   output logic       DATA_MOUSE_OUT_EN,
   input  logic       SEND_BYTE,
   input  logic [7:0] BYTE_TO_SEND,
   output logic       BYTE_SENT,
   output logic [1:0] SEND_ERROR_CODE,
   output logic       BUSY
);
   localparam int MAXC = (TIMEOUT_CYCLES > CLK_HOLD_CYCLES) ? TIMEOUT_CYCLES : CLK_HOLD_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   typedef enum logic [2:0] {IDLE, CLK_LOW, RTS, SEND, WAIT_ACK, WAIT_IDLE} state_t;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    bit_cnt, bit_n;
   logic [10:0]   frame, frame_n;
   logic [1:0]    err_n;
   logic          prev_clk, sent_n, fall, tmo, live;
   assign fall = prev_clk & ~CLK_MOUSE_IN;
   assign tmo  = cnt == CW'(TIMEOUT_CYCLES - 1);
   assign live = state == SEND || state == WAIT_ACK || state == WAIT_IDLE;
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state             <= IDLE;
         cnt               <= '0;
         bit_cnt           <= '0;
         frame             <= '1;
         prev_clk          <= 1'b1;
         SEND_ERROR_CODE   <= 2'b00;
         CLK_MOUSE_OUT_EN  <= 1'b0;
         DATA_MOUSE_OUT_EN <= 1'b0;
         BYTE_SENT         <= 1'b0;
         BUSY              <= 1'b0;
      end else begin
         state             <= state_n;
         cnt               <= cnt_n;
         bit_cnt           <= bit_n;
         frame             <= frame_n;
         prev_clk          <= CLK_MOUSE_IN;
         SEND_ERROR_CODE   <= err_n;
         CLK_MOUSE_OUT_EN  <= state_n == CLK_LOW || state_n == RTS;
         DATA_MOUSE_OUT_EN <= state_n == RTS || (state_n == SEND && !frame_n[0]);
         BYTE_SENT         <= sent_n;
         BUSY              <= state_n != IDLE;
      end
   end
   // frame[0] is always the bit currently on the line; it shifts right on each device falling edge
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      bit_n   = bit_cnt;
      frame_n = frame;
      err_n   = SEND_ERROR_CODE;
      sent_n  = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (SEND_BYTE) begin
               frame_n = {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND, 1'b0};
               err_n   = 2'b00;
               state_n = CLK_LOW;
            end
         end
         CLK_LOW: if (cnt == CW'(CLK_HOLD_CYCLES - 1)) begin
            cnt_n   = '0;
            state_n = RTS;
         end
         RTS: if (cnt == CW'(RTS_OVERLAP_CYCLES - 1)) begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = SEND;
         end
         SEND: if (fall) begin
            cnt_n   = '0;
            frame_n = {1'b1, frame[10:1]};
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == 4'd9) state_n = WAIT_ACK;
         end
         WAIT_ACK: if (fall) begin
            cnt_n    = '0;
            err_n[0] = DATA_MOUSE_IN;
            state_n  = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (CLK_MOUSE_IN && DATA_MOUSE_IN) begin
               sent_n  = 1'b1;
               state_n = IDLE;
            end else if (fall) cnt_n = '0;
         end
         default: state_n = IDLE;
      endcase
      // a falling edge in the same cycle as the timeout keeps the transfer alive
      if (live && !fall && tmo && state_n != IDLE) begin
         err_n[1] = 1'b1;
         sent_n   = 1'b1;
         state_n  = IDLE;
      end
   end
endmodule
